// File: rtl/aether_host_cmd_sequencer.sv
// Host command sequencer: assembles 3-byte host frames into one-cycle decoder
// issues and streams the captured 16-bit decoder result back as 2 bytes.
module aether_host_cmd_sequencer #(
    parameter bit          RespondAll    = 1'b1,
    parameter int unsigned TimeoutCycles = 100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [3:0]  instruction_o,
    output logic [3:0]  param_1_o,
    output logic [15:0] param_2_o,
    input  logic [15:0] data_i,
    input  logic        stall_i,
    output logic        frame_err_o
);

    localparam int unsigned     TmoW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TmoW-1:0] TmoLimit = TmoW'(TimeoutCycles);
    localparam logic [3:0]      OpNop    = 4'h0;
    localparam logic [3:0]      OpRdr    = 4'h1;

    typedef enum logic [2:0] {
        RX0,
        RX1,
        RX2,
        ISSUE,
        TX_HI,
        TX_LO
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       opcode_q;
    logic [3:0]       param_1_q;
    logic [15:0]      param_2_q;
    logic [15:0]      resp_q;
    logic [TmoW-1:0]  tmo_q;
    logic             ld_b0;
    logic             ld_b1;
    logic             ld_b2;
    logic             capture;
    logic             respond;
    logic             in_partial;
    logic             tmo_hit;

    assign respond    = RespondAll || (opcode_q == OpRdr);
    assign in_partial = (state_q == RX1) || (state_q == RX2);
    assign tmo_hit    = (TimeoutCycles != 0) && in_partial && (tmo_q == TmoLimit);

    assign param_1_o  = param_1_q;
    assign param_2_o  = param_2_q;

    // Next-state and handshake decode; a byte arriving on the expiry cycle starts a new frame.
    always_comb begin
        state_d       = state_q;
        rx_ready_o    = 1'b0;
        tx_valid_o    = 1'b0;
        tx_data_o     = 8'h00;
        instruction_o = OpNop;
        frame_err_o   = 1'b0;
        ld_b0         = 1'b0;
        ld_b1         = 1'b0;
        ld_b2         = 1'b0;
        capture       = 1'b0;

        case (state_q)
            RX0: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    ld_b0   = 1'b1;
                    state_d = RX1;
                end
            end
            RX1, RX2: begin
                rx_ready_o = 1'b1;
                if (tmo_hit) begin
                    frame_err_o = 1'b1;
                    ld_b0       = rx_valid_i;
                    state_d     = rx_valid_i ? RX1 : RX0;
                end else if (rx_valid_i) begin
                    ld_b1   = (state_q == RX1);
                    ld_b2   = (state_q == RX2);
                    state_d = (state_q == RX1) ? RX2 : ISSUE;
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    instruction_o = opcode_q;
                    capture       = 1'b1;
                    state_d       = respond ? TX_HI : RX0;
                end
            end
            TX_HI: begin
                tx_valid_o = 1'b1;
                tx_data_o  = resp_q[15:8];
                if (tx_ready_i) state_d = TX_LO;
            end
            TX_LO: begin
                tx_valid_o = 1'b1;
                tx_data_o  = resp_q[7:0];
                if (tx_ready_i) state_d = RX0;
            end
            default: state_d = RX0;
        endcase

        if (!rst_ni) begin
            rx_ready_o    = 1'b0;
            tx_valid_o    = 1'b0;
            tx_data_o     = 8'h00;
            instruction_o = OpNop;
            frame_err_o   = 1'b0;
        end
    end

    // Frame, response and inter-byte timeout registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RX0;
            opcode_q  <= OpNop;
            param_1_q <= 4'h0;
            param_2_q <= 16'h0000;
            resp_q    <= 16'h0000;
            tmo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (ld_b0) begin
                opcode_q  <= rx_data_i[7:4];
                param_1_q <= rx_data_i[3:0];
            end
            if (ld_b1) param_2_q[15:8] <= rx_data_i;
            if (ld_b2) param_2_q[7:0]  <= rx_data_i;
            if (capture) resp_q <= data_i;
            if ((TimeoutCycles == 0) || ld_b0 || ld_b1 || ld_b2 || !in_partial) begin
                tmo_q <= '0;
            end else if (!tmo_hit) begin
                tmo_q <= tmo_q + TmoW'(1);
            end
        end
    end

endmodule

// File: tb/tb_aether_host_cmd_sequencer.sv
// Bench for aether_host_cmd_sequencer: vector table, directed corner sequences
// and a randomized frame stream checked against a frame-level reference model.
module tb_aether_host_cmd_sequencer;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_RDR    = 4'h1;
    localparam logic [3:0] OP_WRR    = 4'h2;
    localparam logic [3:0] REG_VERSN = 4'h0;
    localparam logic [3:0] REG_BCFG1 = 4'h3;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [3:0]  op;
        logic [3:0]  p1;
        logic [15:0] p2;
        logic [15:0] resp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data  [2];
    logic        rx_valid [2];
    logic        rx_ready [2];
    logic [7:0]  tx_data  [2];
    logic        tx_valid [2];
    logic        tx_ready [2];
    logic [3:0]  instr    [2];
    logic [3:0]  p1       [2];
    logic [15:0] p2       [2];
    logic [15:0] data     [2];
    logic        stall    [2];
    logic        ferr     [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Instance 0 responds to every frame with a short timeout; instance 1 answers reads only, no timeout.
    aether_host_cmd_sequencer #(.RespondAll(1'b1), .TimeoutCycles(16)) u_dut_all (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data[0]), .rx_valid_i(rx_valid[0]), .rx_ready_o(rx_ready[0]),
        .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]), .tx_ready_i(tx_ready[0]),
        .instruction_o(instr[0]), .param_1_o(p1[0]), .param_2_o(p2[0]),
        .data_i(data[0]), .stall_i(stall[0]), .frame_err_o(ferr[0])
    );

    aether_host_cmd_sequencer #(.RespondAll(1'b0), .TimeoutCycles(0)) u_dut_rdr (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data[1]), .rx_valid_i(rx_valid[1]), .rx_ready_o(rx_ready[1]),
        .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]), .tx_ready_i(tx_ready[1]),
        .instruction_o(instr[1]), .param_1_o(p1[1]), .param_2_o(p2[1]),
        .data_i(data[1]), .stall_i(stall[1]), .frame_err_o(ferr[1])
    );

    // Minimal decoder stand-in: RDR reads a register, WRR echoes and writes param 2.
    logic [15:0] dec_regs [2][16];
    logic        dec_clear;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            data[k] = 16'h0000;
            if (instr[k] == OP_RDR)      data[k] = dec_regs[k][p1[k]];
            else if (instr[k] == OP_WRR) data[k] = p2[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (dec_clear) begin
                for (int r = 0; r < 16; r++) dec_regs[k][r] <= (r == int'(REG_VERSN)) ? 16'h6C00 : 16'h0000;
            end else if (instr[k] == OP_WRR) begin
                dec_regs[k][p1[k]] <= p2[k];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Random-phase monitor on instance 0: records issues and TX bytes, checks TX hold under backpressure.
    logic        mon_en    = 1'b0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [23:0] issue_q [$];
    logic [7:0]  txq [$];

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (instr[0] != OP_NOP) issue_q.push_back({instr[0], p1[0], p2[0]});
            if (prev_hold) begin
                check_output("rand tx_valid hold", tx_valid[0], 1);
                check_output("rand tx_data hold", tx_data[0], prev_data);
            end
            if (tx_valid[0] && tx_ready[0]) txq.push_back(tx_data[0]);
            prev_hold = tx_valid[0] && !tx_ready[0];
            prev_data = tx_data[0];
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        int t;
        t = 0;
        rx_data[k]  = b;
        rx_valid[k] = 1'b1;
        @(negedge clk);
        while (!rx_ready[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready[k]) check_output("rx_ready wait bound", 0, 1);
        @(posedge clk);
        #1;
        rx_valid[k] = 1'b0;
    endtask

    task automatic apply_stimulus(input int k, input vec_t v);
        send_byte(k, v.b0);
        send_byte(k, v.b1);
        send_byte(k, v.b2);
    endtask

    // Entered at the start of the expected issue cycle; leaves at the start of the next free cycle.
    task automatic check_frame(input int k, input vec_t v, input bit responds, input string tag);
        @(negedge clk);
        check_output({tag, " issue instr"}, instr[k], v.op);
        check_output({tag, " issue p1"}, p1[k], v.p1);
        check_output({tag, " issue p2"}, p2[k], v.p2);
        check_output({tag, " issue rx_ready"}, rx_ready[k], 0);
        idle_cycles(1);
        @(negedge clk);
        if (responds) begin
            check_output({tag, " hi valid"}, tx_valid[k], 1);
            check_output({tag, " hi data"}, tx_data[k], v.resp[15:8]);
            check_output({tag, " hi instr nop"}, instr[k], OP_NOP);
            idle_cycles(1);
            @(negedge clk);
            check_output({tag, " lo valid"}, tx_valid[k], 1);
            check_output({tag, " lo data"}, tx_data[k], v.resp[7:0]);
            idle_cycles(1);
            @(negedge clk);
        end
        check_output({tag, " done tx_valid"}, tx_valid[k], 0);
        check_output({tag, " done rx_ready"}, rx_ready[k], 1);
        check_output({tag, " done instr nop"}, instr[k], OP_NOP);
        idle_cycles(1);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [15:0] resp);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.op = b0[7:4]; v.p1 = b0[3:0]; v.p2 = {b1, b2};
        v.resp = resp;
        return v;
    endfunction

    vec_t vecs [6];

    initial begin
        int          pulses;
        int          pulse_at;
        bit          seen;
        vec_t        v;
        logic [15:0] mregs [16];
        logic [3:0]  rop;
        logic [3:0]  rp1;
        logic [15:0] rp2;
        logic [15:0] rresp;
        logic [23:0] got_issue;
        int          t;

        vecs[0] = '{b0: 8'h10, b1: 8'h00, b2: 8'h00, op: OP_RDR, p1: REG_VERSN, p2: 16'h0000, resp: 16'h6C00};
        vecs[1] = '{b0: 8'h25, b1: 8'hAB, b2: 8'hCD, op: OP_WRR, p1: 4'h5, p2: 16'hABCD, resp: 16'hABCD};
        vecs[2] = '{b0: 8'h15, b1: 8'hFF, b2: 8'hEE, op: OP_RDR, p1: 4'h5, p2: 16'hFFEE, resp: 16'hABCD};
        vecs[3] = '{b0: 8'h07, b1: 8'h11, b2: 8'h22, op: OP_NOP, p1: 4'h7, p2: 16'h1122, resp: 16'h0000};
        vecs[4] = '{b0: 8'hF9, b1: 8'h80, b2: 8'h01, op: 4'hF, p1: 4'h9, p2: 16'h8001, resp: 16'h0000};
        vecs[5] = '{b0: 8'h19, b1: 8'h00, b2: 8'h00, op: OP_RDR, p1: 4'h9, p2: 16'h0000, resp: 16'h0000};

        rst_n = 1'b0;
        dec_clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rx_data[k] = 8'h00; rx_valid[k] = 1'b0; tx_ready[k] = 1'b1; stall[k] = 1'b0;
        end
        idle_cycles(3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_output("reset rx_ready", rx_ready[k], 0);
            check_output("reset tx_valid", tx_valid[k], 0);
            check_output("reset tx_data", tx_data[k], 0);
            check_output("reset instr", instr[k], OP_NOP);
            check_output("reset p1", p1[k], 0);
            check_output("reset p2", p2[k], 0);
            check_output("reset frame_err", ferr[k], 0);
        end
        idle_cycles(1);
        rst_n = 1'b1;
        dec_clear = 1'b0;
        @(negedge clk);
        check_output("release rx_ready", rx_ready[0], 1);
        idle_cycles(1);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, vecs[i]);
            check_frame(0, vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        $display("[TB] stall during issue");
        v = mk(8'h10, 8'h00, 8'h00, 16'h6C00);
        apply_stimulus(0, v);
        stall[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall instr nop", instr[0], OP_NOP);
            check_output("stall rx_ready", rx_ready[0], 0);
            check_output("stall tx_valid", tx_valid[0], 0);
            idle_cycles(1);
        end
        stall[0] = 1'b0;
        check_frame(0, v, 1'b1, "stall");

        $display("[TB] tx backpressure");
        tx_ready[0] = 1'b0;
        v = mk(8'h15, 8'h00, 8'h00, 16'hABCD);
        apply_stimulus(0, v);
        @(negedge clk);
        check_output("bp issue instr", instr[0], OP_RDR);
        idle_cycles(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("bp tx_valid held", tx_valid[0], 1);
            check_output("bp tx_data held", tx_data[0], 8'hAB);
            check_output("bp rx_ready", rx_ready[0], 0);
            idle_cycles(1);
        end
        tx_ready[0] = 1'b1;
        @(negedge clk);
        check_output("bp release hi", tx_data[0], 8'hAB);
        idle_cycles(1);
        @(negedge clk);
        check_output("bp release lo", tx_data[0], 8'hCD);
        check_output("bp release lo valid", tx_valid[0], 1);
        idle_cycles(1);
        @(negedge clk);
        check_output("bp done tx_valid", tx_valid[0], 0);
        check_output("bp done rx_ready", rx_ready[0], 1);
        idle_cycles(1);

        $display("[TB] partial-frame timeout");
        send_byte(0, 8'h47);
        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ferr[0]) begin
                pulses++;
                pulse_at = i;
            end
            idle_cycles(1);
        end
        check_output("timeout pulse count", pulses, 1);
        check_output("timeout pulse cycle", pulse_at, 16);
        v = mk({OP_WRR, REG_BCFG1}, 8'h12, 8'h34, 16'h1234);
        apply_stimulus(0, v);
        check_frame(0, v, 1'b1, "post-timeout");

        send_byte(0, 8'h4B);
        idle_cycles(16);
        rx_data[0]  = {OP_RDR, REG_BCFG1};
        rx_valid[0] = 1'b1;
        @(negedge clk);
        check_output("expiry frame_err", ferr[0], 1);
        check_output("expiry rx_ready", rx_ready[0], 1);
        idle_cycles(1);
        rx_valid[0] = 1'b0;
        send_byte(0, 8'h55);
        send_byte(0, 8'h66);
        v = mk({OP_RDR, REG_BCFG1}, 8'h55, 8'h66, 16'h1234);
        check_frame(0, v, 1'b1, "expiry-byte0");

        $display("[TB] reset mid-frame");
        send_byte(0, 8'h2F);
        send_byte(0, 8'h99);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midrst rx_ready low", rx_ready[0], 0);
        idle_cycles(1);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("midrst rx_ready", rx_ready[0], 1);
        check_output("midrst tx_valid", tx_valid[0], 0);
        check_output("midrst tx_data", tx_data[0], 0);
        check_output("midrst instr", instr[0], OP_NOP);
        check_output("midrst p1", p1[0], 0);
        check_output("midrst p2", p2[0], 0);
        check_output("midrst frame_err", ferr[0], 0);
        idle_cycles(1);
        v = mk(8'h2E, 8'h77, 8'h88, 16'h7788);
        apply_stimulus(0, v);
        check_frame(0, v, 1'b1, "post-reset");

        $display("[TB] read-only responder");
        v = mk({OP_WRR, REG_BCFG1}, 8'h12, 8'h34, 16'h0000);
        apply_stimulus(1, v);
        check_frame(1, v, 1'b0, "r0 wrr");
        v = mk({OP_RDR, REG_BCFG1}, 8'h12, 8'h34, 16'h1234);
        apply_stimulus(1, v);
        check_frame(1, v, 1'b1, "r0 rdr");
        v = mk(8'h07, 8'h00, 8'h00, 16'h0000);
        apply_stimulus(1, v);
        check_frame(1, v, 1'b0, "r0 nop");
        send_byte(1, {OP_RDR, REG_BCFG1});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ferr[1]) seen = 1'b1;
            idle_cycles(1);
        end
        check_output("r0 no timeout", seen, 0);
        send_byte(1, 8'hC0);
        send_byte(1, 8'hDE);
        v = mk({OP_RDR, REG_BCFG1}, 8'hC0, 8'hDE, 16'h1234);
        check_frame(1, v, 1'b1, "r0 slow frame");

        $display("[TB] randomized frames");
        dec_clear = 1'b1;
        idle_cycles(1);
        dec_clear = 1'b0;
        for (int r = 0; r < 16; r++) mregs[r] = (r == int'(REG_VERSN)) ? 16'h6C00 : 16'h0000;
        issue_q.delete();
        txq.delete();
        mon_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 5))
                0:       rop = OP_NOP;
                1, 2:    rop = OP_RDR;
                3, 4:    rop = OP_WRR;
                default: rop = 4'($urandom_range(3, 15));
            endcase
            rp1 = 4'($urandom_range(0, 3));
            rp2 = 16'($urandom);
            rresp = (rop == OP_RDR) ? mregs[rp1] : ((rop == OP_WRR) ? rp2 : 16'h0000);
            if (rop == OP_WRR) mregs[rp1] = rp2;

            send_byte(0, {rop, rp1});
            idle_cycles($urandom_range(0, 3));
            send_byte(0, rp2[15:8]);
            idle_cycles($urandom_range(0, 3));
            send_byte(0, rp2[7:0]);
            t = $urandom_range(0, 3);
            if (t > 0) begin
                stall[0] = 1'b1;
                idle_cycles(t);
                stall[0] = 1'b0;
            end
            t = 0;
            while (txq.size() < 2 && t < 100) begin
                tx_ready[0] = 1'($urandom_range(0, 1));
                idle_cycles(1);
                t++;
            end
            tx_ready[0] = 1'b1;
            if (txq.size() < 2) begin
                check_output("rand response bound", txq.size(), 2);
            end else begin
                check_output($sformatf("rand%0d hi", f), txq.pop_front(), rresp[15:8]);
                check_output($sformatf("rand%0d lo", f), txq.pop_front(), rresp[7:0]);
            end
            check_output($sformatf("rand%0d issue count", f), issue_q.size(), (rop != OP_NOP) ? 1 : 0);
            if (rop != OP_NOP && issue_q.size() > 0) begin
                got_issue = issue_q.pop_front();
                check_output($sformatf("rand%0d issue", f), got_issue, {rop, rp1, rp2});
            end
            issue_q.delete();
            txq.delete();
        end
        mon_en = 1'b0;
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aether_host_cmd_sequencer.md
Name: aether_host_cmd_sequencer

Overview:
- Host-side initiator for the Aether instruction decoder.
- Assembles 3-byte command frames from a host byte stream, such as the UART RX path, into one-cycle instruction/param issues to the decoder.
- Captures the decoder's 16-bit data word in the issue cycle and returns it to the host as 2 bytes on a TX byte stream.
- Sits between the host transport and the decoder inside the Aether engine top.

Parameters:
- RespondAll, 1, 1: every issued frame returns 2 response bytes. 0: only frames whose opcode is RDR respond.
- TimeoutCycles, 100000: idle cycles allowed between bytes of a partial frame before it is discarded. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- rx_data_i  in  8  host command byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  block accepts a byte
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  transport accepts a byte
- instruction_o  out  4  opcode to decoder; NOP (4'h0) when not issuing
- param_1_o  out  4  param 1 to decoder
- param_2_o  out  16  param 2 to decoder
- data_i  in  16  decoder data output (combinational from instruction/params)
- stall_i  in  1  engine busy; defers the issue cycle
- frame_err_o  out  1  one-cycle pulse on partial-frame timeout

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-low (rst_ni).
- Frame format:
  - byte0 = {opcode[3:0], param1[3:0]}
  - byte1 = param2[15:8]
  - byte2 = param2[7:0]
- Handshakes:
  - RX byte transfers on the cycle with rx_valid_i && rx_ready_o.
  - TX byte transfers on the cycle with tx_valid_o && tx_ready_i.
  - tx_valid_o, once high, stays high with tx_data_o stable until the transfer.
- States: RX0, RX1, RX2, ISSUE, TX_HI, TX_LO.
- RX0/RX1/RX2: rx_ready_o=1. Each transfer latches the byte into the frame register and advances. A transfer in RX2 goes to ISSUE.
- ISSUE:
  - rx_ready_o=0.
  - While stall_i=1: instruction_o=NOP; stay in ISSUE.
  - First cycle with stall_i=0: instruction_o=latched opcode for exactly that cycle; data_i captured into the response register at that edge.
  - Next state: TX_HI if responding, else RX0.
- TX_HI: tx_valid_o=1, tx_data_o=resp[15:8]. On transfer go to TX_LO.
- TX_LO: tx_valid_o=1, tx_data_o=resp[7:0]. On transfer go to RX0.
- rx_ready_o=0 in ISSUE/TX_HI/TX_LO, so no byte is accepted until the response completes.
- param_1_o/param_2_o: driven from the frame register continuously; hold the last complete frame's values. They update only when byte0/byte1/byte2 are accepted.
- instruction_o: decoded combinationally from state, stall_i and the opcode register. It is never non-NOP outside ISSUE.
- Latency (no stall, tx_ready_i=1):
  - byte2 transfers at edge N.
  - Issue cycle is N+1.
  - tx_valid_o high (high byte) during N+2; low byte during N+3.
  - Back in RX0 at N+4.
- Timeout:
  - Counter clears on every RX transfer and in RX0, and counts in RX1/RX2.
  - When it reaches TimeoutCycles: state goes to RX0, partial frame discarded, frame_err_o pulses one cycle.
  - A byte transferring in the same cycle as expiry is accepted as byte0 of a new frame.
  - Counter width is clog2(TimeoutCycles+1).
- NOP opcode frames are issued like any other. They respond only when RespondAll=1.
- Reset (any state, including mid-frame or mid-TX):
  - State returns to RX0; partial frame and response discarded.
  - Output reset values: rx_ready_o=0 while rst_ni=0, tx_valid_o=0, tx_data_o=0, instruction_o=NOP, param_1_o=0, param_2_o=0, frame_err_o=0.
  - rx_ready_o=1 from the first cycle after reset release.

Test Plan:
- RespondAll=1, RX bytes {RDR,REG_VERSN},0x00,0x00 with the decoder wired in -> instruction_o=RDR for exactly one cycle, one cycle after byte2; TX emits 0x6C then 0x00.
- RespondAll=0, RX bytes {WRR,REG_BCFG1},0x12,0x34 -> exactly one cycle with instruction_o=WRR, param_1_o=REG_BCFG1, param_2_o=0x1234; no tx_valid_o; readback via RDR returns 0x12,0x34.
- stall_i held high 5 cycles from the cycle after byte2 -> instruction_o=NOP during the stall; single issue in the first cycle stall_i=0; rx_ready_o=0 throughout.
- TimeoutCycles=16, send byte0 then idle -> frame_err_o pulses 16 cycles after the byte0 transfer; the next 3 bytes parse as a fresh frame with correct param values.
- tx_ready_i low for 10 cycles during the response -> tx_data_o stable at the high byte, tx_valid_o held, rx_ready_o=0; bytes are neither reordered nor duplicated after release.
- Assert rst_ni low for 1 cycle after byte1 of a frame -> all outputs at reset values; the subsequent complete frame issues with correct values and no residue from the partial frame.
